proto_field_parser: RTL and testbench
=====================================

# proto_field_parser

Streaming protobuf wire-format parser that sits directly upstream of the metadata lookup stage. It accepts the serialized message byte stream and decodes keys, varints, fixed32/fixed64 values and length prefixes. It tracks embedded-message nesting with a per-level remaining-length stack and emits one field event per field, carrying the identifier path in the same packed `dependency` layout the lookup stage indexes on. Raw length-delimited payloads (strings/bytes) are passed through as a byte stream.

## Interface
- `IDENTIFIER_SIZE`, 4: width of one field identifier; a decoded field number must fit.
- `NUM_MSG_HIERARCHY`, 3: maximum nesting levels; level 0 is the top-level message.
- `LEN_WIDTH`, 16: width of each remaining-length counter.
- `DEPTH_W`, `$clog2(NUM_MSG_HIERARCHY)`: depth field width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid`, `in_ready` in/out 1: input byte handshake.
- `in_data` in 8: serialized byte.
- `in_last` in 1: marks the final byte of the top-level message.
- `tag_valid`, `tag_ready` out/in 1: field-event handshake.
- `tag_path` out `NUM_MSG_HIERARCHY*IDENTIFIER_SIZE`: identifier per level. Level 0 is in bits `[IDENTIFIER_SIZE-1:0]`. Levels above `tag_depth` are zero.
- `tag_depth` out `DEPTH_W`: nesting level of the current field.
- `tag_wire_type` out 3: 0 varint, 1 fixed64, 2 length-delimited, 5 fixed32.
- `tag_value` out 64: varint value, fixed value, or the length when the wire type is 2.
- `ld_descend` in 1: sampled only on an accepted wire-type-2 event. 1 means an embedded message (push a level); 0 means raw bytes.
- `pay_valid`, `pay_ready` out/in 1: raw payload handshake.
- `pay_data` out 8: raw payload byte.
- `pay_last` out 1: marks the final payload byte of the field.
- `err` out 1: sticky error flag.
- `err_code` out 3: 1 bad wire type, 2 varint overlong, 3 field id out of range, 4 depth overflow, 5 length overrun, 6 premature `in_last`.

## Operation
- **States:** KEY, VARINT, FIXED, LENPFX, EMIT, BYTES, ERR.
- **KEY:** accumulate a varint of up to 5 bytes. On completion:
  - field id = key>>3; wire type = key[2:0].
  - A field id of 0 or greater than 2^IDENTIFIER_SIZE−1 sets error 3.
  - Wire types 3, 4, 6 and 7 set error 1.
  - Next state by wire type: VARINT (0), FIXED with 8 bytes (1), LENPFX (2), FIXED with 4 bytes (5).
- **Path write:** `tag_path[depth]` = field id.
- **VARINT:** little-endian groups of 7 bits. More than 10 bytes sets error 2. Bits beyond 64 are dropped.
- **FIXED:** little-endian assembly into `tag_value`, upper bits zero.
- **LENPFX:** varint length into `tag_value`. A length larger than the current level's remaining count (depth>0) sets error 5.
- **EMIT:** hold `tag_valid` until `tag_ready`. While held, `in_ready`=0.
- **Accepted wire-type-2 event with `ld_descend`=1 and length>0:**
  - If depth = NUM_MSG_HIERARCHY−1, set error 4.
  - Otherwise depth++ and the counter at the new level = length.
  - Go to KEY.
- **Accepted wire-type-2 event with `ld_descend`=0 and length>0:** go to BYTES. `pay_data` = `in_data`, `pay_valid` = `in_valid`, `in_ready` = `pay_ready`. `pay_last` is set on byte number `length`.
- **Zero length:** no push and no BYTES; go straight to KEY.
- **Byte accounting:** every accepted input byte decrements the counters of levels 1..depth.
- **Pop:** at the end of each field (after EMIT, or after the last BYTES byte), while depth>0 and the counter at depth is 0, clear `tag_path[depth]` and decrement depth. Multiple levels may pop in the same cycle.
- **`in_last`:**
  - Legal only on the byte that completes a field and leaves depth 0 after pops. Otherwise set error 6.
  - After `in_last`, the parser returns to KEY with depth 0 and `tag_path` = 0.
- **ERR:** sticky until `rst`. `in_ready`=1 (drain), `tag_valid`=0, `pay_valid`=0.

## Timing
- **Reset values:** `in_ready`=1, `tag_valid`=0, `tag_path`=0, `tag_depth`=0, `tag_wire_type`=0, `tag_value`=0, `pay_valid`=0, `pay_last`=0, `err`=0, `err_code`=0. State = KEY; all counters 0.
- **Reset mid-field:** the partial field is discarded; no event is emitted.
- **Event latency:** `tag_valid` rises the cycle after the value's final byte (or the final length byte) is accepted.
- **Throughput:** one byte per cycle when there is no backpressure; one bubble per field (EMIT).
- **Handshakes:** outputs hold stable while `valid && !ready`. The payload path is combinational, zero latency.
- **Error timing:** `err` asserts the cycle after the offending byte and no event is emitted for that field.

## Test plan
- **Nested message:** feed `0A 07 0A 02 61 62 10 96 01` with `in_last` on the final byte; descend=1 for the first event, 0 for the second. Required:
  - Event 1: path{0,0,1}, depth 0, wt 2, value 7.
  - Event 2: path{0,1,1}, depth 1, wt 2, value 2.
  - Payload `61`, then `62` with `pay_last`.
  - Event 3: path{0,2,1}, depth 1, wt 0, value 150.
  - Then depth 0 and `err`=0.
- **Fixed32:** `1D 78 56 34 12` → path{0,0,3}, wt 5, value 0x12345678. **Fixed64:** `09 01..08` → value 0x0807060504030201.
- **Errors:**
  - `0B` → err, code 1.
  - `80 01` (field 16) → code 3.
  - A varint of 11 bytes of `FF` → code 2.
  - A fourth nesting level → code 4.
  - Inner length 9 inside remaining 7 → code 5.
- **Backpressure:** hold `tag_ready`=0 for 5 cycles → `in_ready`=0 and the event stays stable. Toggle `pay_ready` → no bytes lost or duplicated.
- **Boundaries:**
  - `in_last` mid-varint → code 6.
  - A zero-length embedded field `0A 00` → one event, depth unchanged.
  - Assert `rst` mid-payload → all outputs return to reset values and the next message parses cleanly.

Source files
------------

// File: rtl/proto_field_parser.sv
// proto_field_parser
// Streaming protobuf wire-format decoder. Consumes a serialized message one
// byte at a time, decodes keys, varints, fixed32/fixed64 values and length
// prefixes, tracks embedded-message nesting with a per-level remaining-length
// stack and emits one field event per field. Raw length-delimited payloads are
// forwarded combinationally on the pay_* stream.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     serialized input byte stream
//   in_last                       final byte of the top-level message
//   tag_valid/tag_ready           field-event handshake
//   tag_path                      field id per nesting level (level 0 in LSBs)
//   tag_depth                     nesting level of the emitted field
//   tag_wire_type, tag_value      wire type and decoded value / length
//   ld_descend                    on a wire-type-2 event: 1 = embedded message
//   pay_valid/pay_ready/pay_data  raw payload bytes, pay_last on final byte
//   err, err_code                 sticky error flag and cause
module proto_field_parser #(
  parameter int IDENTIFIER_SIZE   = 4,
  parameter int NUM_MSG_HIERARCHY = 3,
  parameter int LEN_WIDTH         = 16,
  parameter int DEPTH_W           = $clog2(NUM_MSG_HIERARCHY)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [7:0]                                   in_data,
  input  logic                                         in_last,
  output logic                                         tag_valid,
  input  logic                                         tag_ready,
  output logic [NUM_MSG_HIERARCHY*IDENTIFIER_SIZE-1:0] tag_path,
  output logic [DEPTH_W-1:0]                           tag_depth,
  output logic [2:0]                                   tag_wire_type,
  output logic [63:0]                                  tag_value,
  input  logic                                         ld_descend,
  output logic                                         pay_valid,
  input  logic                                         pay_ready,
  output logic [7:0]                                   pay_data,
  output logic                                         pay_last,
  output logic                                         err,
  output logic [2:0]                                   err_code
);

  localparam logic [2:0] S_KEY    = 3'd0;
  localparam logic [2:0] S_VARINT = 3'd1;
  localparam logic [2:0] S_FIXED  = 3'd2;
  localparam logic [2:0] S_LENPFX = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;
  localparam logic [2:0] S_BYTES  = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [2:0] E_WIRE     = 3'd1;
  localparam logic [2:0] E_OVERLONG = 3'd2;
  localparam logic [2:0] E_FIELD    = 3'd3;
  localparam logic [2:0] E_DEPTH    = 3'd4;
  localparam logic [2:0] E_LEN      = 3'd5;
  localparam logic [2:0] E_LAST     = 3'd6;

  localparam logic [31:0]        MAX_ID    = 32'((1 << IDENTIFIER_SIZE) - 1);
  localparam logic [DEPTH_W-1:0] TOP_DEPTH = DEPTH_W'(NUM_MSG_HIERARCHY - 1);

  typedef logic [NUM_MSG_HIERARCHY-1:0][IDENTIFIER_SIZE-1:0] path_t;
  typedef logic [NUM_MSG_HIERARCHY-1:0][LEN_WIDTH-1:0]       cnt_t;

  logic [2:0]           state_reg, state_next;
  logic [DEPTH_W-1:0]   depth_reg, depth_next;
  path_t                path_reg, path_next;
  cnt_t                 cnt_reg, cnt_next, cnt_dec;
  logic [63:0]          value_reg, value_next;
  logic [34:0]          key_reg, key_next;
  logic [3:0]           idx_reg, idx_next;
  logic [2:0]           wt_reg, wt_next;
  logic                 fix64_reg, fix64_next;
  logic [LEN_WIDTH-1:0] pay_cnt_reg, pay_cnt_next;
  logic                 last_pend_reg, last_pend_next;
  logic                 err_reg, err_next;
  logic [2:0]           err_code_reg, err_code_next;

  logic                 in_acc, byte_acc;
  logic [6:0]           shamt7;
  logic [5:0]           shamt8;
  logic [34:0]          key_full;
  logic [31:0]          key_fid;
  logic [2:0]           key_wt;
  logic [63:0]          var_full, fix_full;
  logic [DEPTH_W-1:0]   depth_inc;
  logic                 all_done;
  logic [DEPTH_W-1:0]   pop_depth;
  path_t                pop_path;
  logic                 fail, field_end, end_clear;
  logic [2:0]           fail_code;

  assign in_ready  = (state_reg == S_EMIT)  ? 1'b0 :
                     (state_reg == S_BYTES) ? pay_ready : 1'b1;
  assign in_acc    = in_valid && in_ready;
  assign byte_acc  = in_acc && (state_reg != S_ERR);

  assign tag_valid     = (state_reg == S_EMIT);
  assign tag_path      = path_reg;
  assign tag_depth     = depth_reg;
  assign tag_wire_type = wt_reg;
  assign tag_value     = value_reg;
  assign pay_data      = in_data;
  assign pay_valid     = (state_reg == S_BYTES) && in_valid;
  assign pay_last      = (state_reg == S_BYTES) && (pay_cnt_reg == LEN_WIDTH'(1));
  assign err           = err_reg;
  assign err_code      = err_code_reg;

  // 7-bit groups for varints, 8-bit lanes for fixed values; bits shifted past
  // the accumulator width fall off, which drops varint bits beyond 64.
  assign shamt7    = 7'(idx_reg) * 7'd7;
  assign shamt8    = {idx_reg[2:0], 3'b000};
  assign key_full  = key_reg | ({28'd0, in_data[6:0]} << shamt7);
  assign key_fid   = key_full[34:3];
  assign key_wt    = key_full[2:0];
  assign var_full  = value_reg | ({57'd0, in_data[6:0]} << shamt7);
  assign fix_full  = value_reg | ({56'd0, in_data} << shamt8);
  assign depth_inc = depth_reg + 1'b1;

  // Every accepted byte is consumed by each open embedded message.
  generate
    for (genvar gi = 0; gi < NUM_MSG_HIERARCHY; gi++) begin : g_cnt
      if (gi == 0) begin : g_top
        assign cnt_dec[gi] = '0;
      end else begin : g_nest
        assign cnt_dec[gi] = (byte_acc && (DEPTH_W'(gi) <= depth_reg)) ?
                             cnt_reg[gi] - 1'b1 : cnt_reg[gi];
      end
    end
  endgenerate

  // Pops cascade from the innermost level so several levels may close at once.
  always_comb begin
    all_done  = 1'b1;
    pop_depth = depth_reg;
    pop_path  = path_reg;
    for (int i = NUM_MSG_HIERARCHY - 1; i >= 1; i--) begin
      if ((DEPTH_W'(i) <= depth_reg) && (cnt_dec[i] != '0)) all_done = 1'b0;
      if ((pop_depth == DEPTH_W'(i)) && (cnt_dec[i] == '0)) begin
        pop_path[i] = '0;
        pop_depth   = DEPTH_W'(i - 1);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    depth_next     = depth_reg;
    path_next      = path_reg;
    cnt_next       = cnt_dec;
    value_next     = value_reg;
    key_next       = key_reg;
    idx_next       = idx_reg;
    wt_next        = wt_reg;
    fix64_next     = fix64_reg;
    pay_cnt_next   = pay_cnt_reg;
    last_pend_next = last_pend_reg;
    err_next       = err_reg;
    err_code_next  = err_code_reg;
    fail           = 1'b0;
    fail_code      = '0;
    field_end      = 1'b0;
    end_clear      = 1'b0;

    case (state_reg)
      S_KEY: if (in_acc) begin
        if (in_data[7]) begin
          if (idx_reg == 4'd4) begin
            fail = 1'b1; fail_code = E_OVERLONG;
          end else if (in_last) begin
            fail = 1'b1; fail_code = E_LAST;
          end else begin
            key_next = key_full;
            idx_next = idx_reg + 1'b1;
          end
        end else if (key_wt inside {3'd3, 3'd4, 3'd6, 3'd7}) begin
          fail = 1'b1; fail_code = E_WIRE;
        end else if ((key_fid == 32'd0) || (key_fid > MAX_ID)) begin
          fail = 1'b1; fail_code = E_FIELD;
        end else if (in_last) begin
          fail = 1'b1; fail_code = E_LAST;
        end else begin
          path_next[depth_reg] = key_fid[IDENTIFIER_SIZE-1:0];
          wt_next    = key_wt;
          fix64_next = (key_wt == 3'd1);
          key_next   = '0;
          idx_next   = '0;
          value_next = '0;
          case (key_wt)
            3'd0:    state_next = S_VARINT;
            3'd2:    state_next = S_LENPFX;
            default: state_next = S_FIXED;
          endcase
        end
      end

      S_VARINT, S_LENPFX: if (in_acc) begin
        if (idx_reg == 4'd10) begin
          fail = 1'b1; fail_code = E_OVERLONG;
        end else begin
          value_next = var_full;
          idx_next   = idx_reg + 1'b1;
          if (!in_data[7]) begin
            if ((state_reg == S_LENPFX) &&
                ((var_full[63:LEN_WIDTH] != '0) ||
                 ((depth_reg != '0) && (var_full[LEN_WIDTH-1:0] > cnt_dec[depth_reg])))) begin
              fail = 1'b1; fail_code = E_LEN;
            end else if (in_last && (!all_done ||
                         ((state_reg == S_LENPFX) && (var_full != 64'd0)))) begin
              // A non-empty length prefix cannot finish the message.
              fail = 1'b1; fail_code = E_LAST;
            end else begin
              last_pend_next = in_last;
              state_next     = S_EMIT;
            end
          end else if (in_last) begin
            fail = 1'b1; fail_code = E_LAST;
          end
        end
      end

      S_FIXED: if (in_acc) begin
        value_next = fix_full;
        idx_next   = idx_reg + 1'b1;
        if (idx_reg[2:0] == (fix64_reg ? 3'd7 : 3'd3)) begin
          if (in_last && !all_done) begin
            fail = 1'b1; fail_code = E_LAST;
          end else begin
            last_pend_next = in_last;
            state_next     = S_EMIT;
          end
        end else if (in_last) begin
          fail = 1'b1; fail_code = E_LAST;
        end
      end

      S_EMIT: if (tag_ready) begin
        idx_next = '0;
        if ((wt_reg == 3'd2) && (value_reg != 64'd0)) begin
          if (ld_descend) begin
            if (depth_reg == TOP_DEPTH) begin
              fail = 1'b1; fail_code = E_DEPTH;
            end else begin
              depth_next          = depth_inc;
              cnt_next[depth_inc] = value_reg[LEN_WIDTH-1:0];
              state_next          = S_KEY;
            end
          end else begin
            pay_cnt_next = value_reg[LEN_WIDTH-1:0];
            state_next   = S_BYTES;
          end
        end else begin
          field_end = 1'b1;
          end_clear = last_pend_reg;
        end
      end

      S_BYTES: if (in_acc) begin
        pay_cnt_next = pay_cnt_reg - 1'b1;
        if (pay_cnt_reg == LEN_WIDTH'(1)) begin
          if (in_last && !all_done) begin
            fail = 1'b1; fail_code = E_LAST;
          end else begin
            field_end = 1'b1;
            end_clear = in_last;
          end
        end else if (in_last) begin
          fail = 1'b1; fail_code = E_LAST;
        end
      end

      S_ERR: ;

      default: state_next = S_KEY;
    endcase

    if (field_end) begin
      state_next     = S_KEY;
      last_pend_next = 1'b0;
      if (end_clear) begin
        depth_next = '0;
        path_next  = '0;
        cnt_next   = '0;
      end else begin
        depth_next = pop_depth;
        path_next  = pop_path;
      end
    end

    // A byte arriving after an embedded message has been fully consumed means
    // an inner field ran past its enclosing length.
    if (byte_acc && (depth_reg != '0) && (cnt_reg[depth_reg] == '0)) begin
      fail = 1'b1; fail_code = E_LEN;
    end

    if (fail) begin
      state_next    = S_ERR;
      err_next      = 1'b1;
      err_code_next = fail_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_KEY;
      depth_reg     <= '0;
      path_reg      <= '0;
      cnt_reg       <= '0;
      value_reg     <= '0;
      key_reg       <= '0;
      idx_reg       <= '0;
      wt_reg        <= '0;
      fix64_reg     <= 1'b0;
      pay_cnt_reg   <= '0;
      last_pend_reg <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      depth_reg     <= depth_next;
      path_reg      <= path_next;
      cnt_reg       <= cnt_next;
      value_reg     <= value_next;
      key_reg       <= key_next;
      idx_reg       <= idx_next;
      wt_reg        <= wt_next;
      fix64_reg     <= fix64_next;
      pay_cnt_reg   <= pay_cnt_next;
      last_pend_reg <= last_pend_next;
      err_reg       <= err_next;
      err_code_reg  <= err_code_next;
    end
  end

endmodule

// File: tb/tb_proto_field_parser.sv
// tb_proto_field_parser
// Scoreboard bench: expected field events and payload bytes are queued when a
// message is driven and compared as the parser hands them out.
module tb_proto_field_parser;

  localparam int IDS = 4;
  localparam int NH  = 3;
  localparam int DW  = 2;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      in_data;
  logic            in_last;
  logic            tag_valid;
  logic            tag_ready;
  logic [NH*IDS-1:0] tag_path;
  logic [DW-1:0]   tag_depth;
  logic [2:0]      tag_wire_type;
  logic [63:0]     tag_value;
  logic            ld_descend;
  logic            pay_valid;
  logic            pay_ready;
  logic [7:0]      pay_data;
  logic            pay_last;
  logic            err;
  logic [2:0]      err_code;

  proto_field_parser #(
    .IDENTIFIER_SIZE(IDS), .NUM_MSG_HIERARCHY(NH), .LEN_WIDTH(16), .DEPTH_W(DW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .tag_valid(tag_valid), .tag_ready(tag_ready), .tag_path(tag_path),
    .tag_depth(tag_depth), .tag_wire_type(tag_wire_type), .tag_value(tag_value),
    .ld_descend(ld_descend),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data), .pay_last(pay_last),
    .err(err), .err_code(err_code)
  );

  typedef struct {
    logic [NH*IDS-1:0] path;
    logic [DW-1:0]     depth;
    logic [2:0]        wt;
    logic [63:0]       value;
    logic              desc;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } pb_t;

  ev_t        ev_q[$];
  pb_t        pb_q[$];
  logic [7:0] tx_q[$];
  int         checks    = 0;
  int         failures  = 0;
  int         spurious  = 0;
  bit         pr_rand   = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_ev(input logic [NH*IDS-1:0] p, input logic [DW-1:0] d,
                         input logic [2:0] w, input logic [63:0] v, input logic ds);
    ev_t e;
    e.path = p; e.depth = d; e.wt = w; e.value = v; e.desc = ds;
    ev_q.push_back(e);
  endtask

  task automatic push_pay(input logic [7:0] d, input logic l);
    pb_t p;
    p.data = d; p.last = l;
    pb_q.push_back(p);
  endtask

  // Drives tx_q byte by byte, each held until accepted.
  task automatic send_msg(input bit with_last);
    int n;
    bit acc;
    n = tx_q.size();
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = tx_q[i];
      in_last  = with_last && (i == n - 1);
      for (int c = 0; c < 200 && !acc; c++) begin
        #4;
        acc = in_ready;
        @(posedge clk);
        if (!acc) @(negedge clk);
      end
      if (!acc) check("send_timeout", 64'(acc), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tx_q.delete();
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((ev_q.size() != 0 || pb_q.size() != 0) && c < 300) begin
      @(posedge clk);
      c++;
    end
    check("drain_left", 64'(ev_q.size() + pb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    #4;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ev_q.delete(); pb_q.delete();
    spurious = 0;
  endtask

  task automatic check_idle();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_tag_valid", 64'(tag_valid), 64'd0);
    check("rst_tag_path", 64'(tag_path), 64'd0);
    check("rst_tag_depth", 64'(tag_depth), 64'd0);
    check("rst_tag_wt", 64'(tag_wire_type), 64'd0);
    check("rst_tag_value", tag_value, 64'd0);
    check("rst_pay_valid", 64'(pay_valid), 64'd0);
    check("rst_pay_last", 64'(pay_last), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
  endtask

  task automatic expect_err(input string tag, input logic [2:0] code);
    repeat (2) @(negedge clk);
    #4;
    check({tag, "_err"}, 64'(err), 64'd1);
    check({tag, "_code"}, 64'(err_code), 64'(code));
    check({tag, "_no_tag"}, 64'(tag_valid), 64'd0);
    check({tag, "_spurious"}, 64'(spurious), 64'd0);
    check({tag, "_exp_left"}, 64'(ev_q.size()), 64'd0);
  endtask

  // Monitor: compares every accepted event and payload byte with the queue head.
  initial begin
    ev_t e;
    pb_t p;
    ld_descend = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      ld_descend = (ev_q.size() > 0) ? ev_q[0].desc : 1'b0;
      if (tag_valid && tag_ready) begin
        $display("tag path=%h depth=%0d wt=%0d value=%h", tag_path, tag_depth, tag_wire_type, tag_value);
        if (ev_q.size() == 0) begin
          spurious++;
        end else begin
          e = ev_q.pop_front();
          check("tag_path", 64'(tag_path), 64'(e.path));
          check("tag_depth", 64'(tag_depth), 64'(e.depth));
          check("tag_wt", 64'(tag_wire_type), 64'(e.wt));
          check("tag_value", tag_value, e.value);
        end
      end
      if (pay_valid && pay_ready) begin
        $display("pay data=%h last=%0d", pay_data, pay_last);
        if (pb_q.size() == 0) begin
          spurious++;
        end else begin
          p = pb_q.pop_front();
          check("pay_data", 64'(pay_data), 64'(p.data));
          check("pay_last", 64'(pay_last), 64'(p.last));
        end
      end
    end
  end

  initial begin
    pay_ready = 1'b1;
    forever begin
      @(negedge clk);
      pay_ready = pr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; tag_ready = 1'b1;
    repeat (3) @(negedge clk);
    #4;
    check_idle();
    @(negedge clk);
    rst = 1'b0;

    // Nested message with a raw payload inside, payload backpressure toggling.
    pr_rand = 1'b1;
    push_ev(12'h001, 2'd0, 3'd2, 64'd7, 1'b1);
    push_ev(12'h011, 2'd1, 3'd2, 64'd2, 1'b0);
    push_pay(8'h61, 1'b0);
    push_pay(8'h62, 1'b1);
    push_ev(12'h021, 2'd1, 3'd0, 64'd150, 1'b0);
    tx_q = '{8'h0A, 8'h07, 8'h0A, 8'h02, 8'h61, 8'h62, 8'h10, 8'h96, 8'h01};
    send_msg(1'b1);
    wait_drain();
    pr_rand = 1'b0;
    check("nest_depth_end", 64'(tag_depth), 64'd0);
    check("nest_path_end", 64'(tag_path), 64'd0);
    check("nest_err", 64'(err), 64'd0);
    check("nest_spurious", 64'(spurious), 64'd0);

    // Zero-length embedded message inside a nested one: no extra level.
    push_ev(12'h001, 2'd0, 3'd2, 64'd2, 1'b1);
    push_ev(12'h011, 2'd1, 3'd2, 64'd0, 1'b1);
    tx_q = '{8'h0A, 8'h02, 8'h0A, 8'h00};
    send_msg(1'b1);
    wait_drain();
    check("zlen_depth_end", 64'(tag_depth), 64'd0);
    check("zlen_err", 64'(err), 64'd0);

    // Fixed32 with the event held for 5 cycles.
    tag_ready = 1'b0;
    push_ev(12'h003, 2'd0, 3'd5, 64'h12345678, 1'b0);
    tx_q = '{8'h1D, 8'h78, 8'h56, 8'h34, 8'h12};
    send_msg(1'b1);
    for (int i = 0; i < 5; i++) begin
      #4;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_tag_valid", 64'(tag_valid), 64'd1);
      check("bp_tag_value", tag_value, 64'h12345678);
      check("bp_tag_path", 64'(tag_path), 64'h003);
      @(negedge clk);
    end
    tag_ready = 1'b1;
    wait_drain();

    // Fixed64.
    push_ev(12'h001, 2'd0, 3'd1, 64'h0807060504030201, 1'b0);
    tx_q = '{8'h09, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_msg(1'b1);
    wait_drain();

    // Raw string with random payload backpressure.
    pr_rand = 1'b1;
    push_ev(12'h002, 2'd0, 3'd2, 64'd5, 1'b0);
    push_pay(8'h68, 1'b0); push_pay(8'h65, 1'b0); push_pay(8'h6C, 1'b0);
    push_pay(8'h6C, 1'b0); push_pay(8'h6F, 1'b1);
    tx_q = '{8'h12, 8'h05, 8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    send_msg(1'b1);
    wait_drain();
    pr_rand = 1'b0;
    check("str_spurious", 64'(spurious), 64'd0);
    check("str_err", 64'(err), 64'd0);

    // Error cases.
    do_reset();
    tx_q = '{8'h0B};
    send_msg(1'b0);
    expect_err("bad_wt", 3'd1);
    check("err_drain_ready", 64'(in_ready), 64'd1);

    do_reset();
    tx_q = '{8'h80, 8'h01};
    send_msg(1'b0);
    expect_err("field16", 3'd3);

    do_reset();
    tx_q = '{8'h08};
    for (int i = 0; i < 11; i++) tx_q.push_back(8'hFF);
    send_msg(1'b0);
    expect_err("overlong", 3'd2);

    do_reset();
    push_ev(12'h001, 2'd0, 3'd2, 64'd6, 1'b1);
    push_ev(12'h011, 2'd1, 3'd2, 64'd4, 1'b1);
    push_ev(12'h111, 2'd2, 3'd2, 64'd2, 1'b1);
    tx_q = '{8'h0A, 8'h06, 8'h0A, 8'h04, 8'h0A, 8'h02};
    send_msg(1'b0);
    wait_drain();
    expect_err("depth", 3'd4);

    do_reset();
    push_ev(12'h001, 2'd0, 3'd2, 64'd7, 1'b1);
    tx_q = '{8'h0A, 8'h07, 8'h0A, 8'h09};
    send_msg(1'b0);
    wait_drain();
    expect_err("overrun", 3'd5);

    do_reset();
    tx_q = '{8'h08, 8'h96};
    send_msg(1'b1);
    expect_err("early_last", 3'd6);

    // Reset in the middle of a payload, then a clean message.
    do_reset();
    push_ev(12'h002, 2'd0, 3'd2, 64'd5, 1'b0);
    push_pay(8'h68, 1'b0);
    push_pay(8'h65, 1'b0);
    tx_q = '{8'h12, 8'h05, 8'h68, 8'h65};
    send_msg(1'b0);
    wait_drain();
    check("mid_spurious", 64'(spurious), 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #2;
    check_idle();
    @(negedge clk);
    rst = 1'b0;
    push_ev(12'h003, 2'd0, 3'd5, 64'h12345678, 1'b0);
    tx_q = '{8'h1D, 8'h78, 8'h56, 8'h34, 8'h12};
    send_msg(1'b1);
    wait_drain();
    check("post_rst_err", 64'(err), 64'd0);
    check("post_rst_spurious", 64'(spurious), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
